// File: rtl/mux_pkg.sv
//------------------------------------------------------------------------------
// Module      : mux_pkg
// Description : Shared constants and helpers for the pipelined N:1 mux.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  // Largest supported input count
  localparam int MUX_MAX_IN = 16;

  // Default datapath width, shared with the core
  localparam int XLEN = 32;

  // ceil(log2(n)), never less than 1 so a 1-bit select always exists
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage : mux_pkg

`default_nettype wire

// File: rtl/mux_n_comb.sv
//------------------------------------------------------------------------------
// Module      : mux_n_comb
// Description : Purely combinational N:1 selector with out-of-range flag.
//               An out-of-range select yields all-zero data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_n_comb
  import mux_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err
);

  // One extra bit so NUM_IN itself is representable when it is a power of 2
  localparam logic [SEL_W:0] C_NUM_IN = NUM_IN[SEL_W:0];

  // Decode sel against every legal index; unmatched indices leave zero data
  always_comb begin
    data_out = '0;
    sel_err  = ({1'b0, sel} >= C_NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) data_out = data_in[k*WIDTH +: WIDTH];
    end
  end

endmodule : mux_n_comb

`default_nettype wire

// File: rtl/mux_pipe_n.sv
//------------------------------------------------------------------------------
// Module      : mux_pipe_n
// Description : One-stage pipelined N:1 datapath multiplexer with valid
//               tracking, stall/flush control and out-of-range detection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_pipe_n
  import mux_pkg::*;
#(
  parameter  int WIDTH  = XLEN,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_range_err;

  logic             valid_d,   valid_q;
  logic [WIDTH-1:0] data_d,    data_q;
  logic             sel_err_d, sel_err_q;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .sel      (sel),
    .data_in  (data_in),
    .data_out (sel_data),
    .sel_err  (sel_range_err)
  );

  // Next-state: flush beats stall beats normal capture; in_valid=0 keeps data
  // so an X on sel/data_in while idle never reaches the output register
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    sel_err_d = sel_err_q;
    if (flush) begin
      valid_d   = 1'b0;
      data_d    = '0;
      sel_err_d = 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        valid_d   = 1'b1;
        data_d    = sel_data;
        sel_err_d = sel_range_err;
      end else begin
        valid_d   = 1'b0;
        sel_err_d = 1'b0;
      end
    end
  end

  // Output stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out_valid = valid_q;
  assign data_out  = data_q;
  assign sel_err   = sel_err_q;

endmodule : mux_pipe_n

`default_nettype wire

// File: tb/tb_mux_pipe_n.sv
//------------------------------------------------------------------------------
// Module      : tb_mux_pipe_n
// Description : Directed self-checking bench for mux_pipe_n, covering
//               NUM_IN = 4, 3 and 2 instances.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_pipe_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         stall;
  logic         flush;

  logic [1:0]   sel4;
  logic [127:0] d4;
  logic         v4, e4;
  logic [31:0]  q4;

  logic [1:0]   sel3;
  logic [95:0]  d3;
  logic         v3, e3;
  logic [31:0]  q3;

  logic [0:0]   sel2;
  logic [63:0]  d2;
  logic         v2, e2;
  logic [31:0]  q2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel4), .data_in(d4),
    .stall(stall), .flush(flush), .out_valid(v4), .data_out(q4), .sel_err(e4)
  );

  mux_pipe_n #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel3), .data_in(d3),
    .stall(stall), .flush(flush), .out_valid(v3), .data_out(q3), .sel_err(e3)
  );

  mux_pipe_n #(.WIDTH(32), .NUM_IN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel2), .data_in(d2),
    .stall(stall), .flush(flush), .out_valid(v2), .data_out(q2), .sel_err(e2)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    sel4 = '0; sel3 = '0; sel2 = '0;
    d4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    d3 = {32'h33333333, 32'hDEADBEEF, 32'h11111111};
    d2 = '0;
    #3;
    n_checks++; if (v4 !== 1'b0)     begin n_fail++; $display("FAIL reset_valid: got %b expected 0", v4); end
    n_checks++; if (q4 !== 32'h0)    begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", q4); end
    n_checks++; if (e4 !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b expected 0", e4); end
    step(); step();
    rst_n = 1'b1;
    in_valid = 1'b1; sel4 = 2'd2;
    step();
    n_checks++; if (v4 !== 1'b1 || q4 !== 32'h33333333) begin n_fail++; $display("FAIL pre_async: got v=%b d=%h expected v=1 d=33333333", v4, q4); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (v4 !== 1'b0 || q4 !== 32'h0 || e4 !== 1'b0) begin n_fail++; $display("FAIL async_reset: got v=%b d=%h e=%b expected v=0 d=00000000 e=0", v4, q4, e4); end
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (v4 !== 1'b1 || q4 !== 32'h33333333) begin n_fail++; $display("FAIL first_edge_after_reset: got v=%b d=%h expected v=1 d=33333333", v4, q4); end
  endtask

  task automatic test_select_sweep();
    logic [31:0] exp;
    in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      exp  = 32'h11111111 * (s + 1);
      step();
      n_checks++;
      if (q4 !== exp || v4 !== 1'b1 || e4 !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep_sel%0d: got v=%b d=%h e=%b expected v=1 d=%h e=0", s, v4, q4, e4, exp);
      end
    end
  endtask

  task automatic test_idle_hold();
    // Last capture was 0x44444444; idle cycle with X inputs must keep it
    in_valid = 1'b0; sel4 = 'x; d4 = 'x;
    step();
    n_checks++; if (v4 !== 1'b0 || q4 !== 32'h44444444 || e4 !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got v=%b d=%h e=%b expected v=0 d=44444444 e=0", v4, q4, e4); end
    d4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    sel4 = '0;
  endtask

  task automatic test_out_of_range();
    in_valid = 1'b1; sel3 = 2'd3;
    step();
    n_checks++; if (q3 !== 32'h0 || v3 !== 1'b1 || e3 !== 1'b1) begin n_fail++; $display("FAIL oor_sel3: got v=%b d=%h e=%b expected v=1 d=00000000 e=1", v3, q3, e3); end
    sel3 = 2'd1;
    step();
    n_checks++; if (q3 !== 32'hDEADBEEF || v3 !== 1'b1 || e3 !== 1'b0) begin n_fail++; $display("FAIL oor_recover: got v=%b d=%h e=%b expected v=1 d=deadbeef e=0", v3, q3, e3); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; sel4 = 2'd0;
    d4 = {32'h44444444, 32'h33333333, 32'h0BADF00D, 32'hA5A5A5A5};
    step();
    n_checks++; if (q4 !== 32'hA5A5A5A5 || v4 !== 1'b1) begin n_fail++; $display("FAIL stall_capture: got v=%b d=%h expected v=1 d=a5a5a5a5", v4, q4); end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sel4 = 2'(c + 1);
      d4   = d4 ^ {4{32'h01010101}};
      step();
      n_checks++;
      if (q4 !== 32'hA5A5A5A5 || v4 !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got v=%b d=%h expected v=1 d=a5a5a5a5", c, v4, q4);
      end
    end
    stall = 1'b0; sel4 = 2'd1;
    d4 = {32'h44444444, 32'h33333333, 32'h0BADF00D, 32'hA5A5A5A5};
    step();
    n_checks++; if (q4 !== 32'h0BADF00D || v4 !== 1'b1) begin n_fail++; $display("FAIL stall_release: got v=%b d=%h expected v=1 d=0badf00d", v4, q4); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; sel4 = 2'd3; sel3 = 2'd3;
    step();
    n_checks++; if (v4 !== 1'b1 || q4 !== 32'h44444444 || e3 !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got v=%b d=%h e3=%b expected v=1 d=44444444 e3=1", v4, q4, e3); end
    stall = 1'b1; flush = 1'b1;
    step();
    n_checks++; if (v4 !== 1'b0 || q4 !== 32'h0 || e4 !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall: got v=%b d=%h e=%b expected v=0 d=00000000 e=0", v4, q4, e4); end
    n_checks++; if (v3 !== 1'b0 || q3 !== 32'h0 || e3 !== 1'b0) begin n_fail++; $display("FAIL flush_err_clear: got v=%b d=%h e=%b expected v=0 d=00000000 e=0", v3, q3, e3); end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_back_to_back_legacy();
    logic [31:0] a, b, exp;
    logic        s;
    int          bad;
    bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      d2 = {b, a}; sel2 = s;
      exp = s ? b : a;
      step();
      n_checks++;
      if (q2 !== exp || v2 !== 1'b1 || e2 !== 1'b0) begin
        n_fail++;
        if (bad < 10) $display("FAIL legacy_vec%0d: got v=%b d=%h e=%b expected v=1 d=%h e=0", i, v2, q2, e2, exp);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_idle_hold();
    test_out_of_range();
    test_stall();
    test_flush();
    test_back_to_back_legacy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_pipe_n

`default_nettype wire

// File: doc/mux_pipe_n.md
# mux_pipe_n

Parametrised N-input, one-stage pipelined datapath multiplexer for the RISC-V core. It supersedes the 2:1 combinational select used for operand, forwarding and write-back selection. It adds a registered output with valid tracking, a stall/flush interface matching the pipeline control signals, and out-of-range select detection. It sits at pipeline-stage boundaries where the selected value must be captured in the same cycle as the stage register.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- NUM_IN, 4, number of data inputs; legal range 2..16
- SEL_W, derived localparam = max(1, ceil(log2(NUM_IN))); not overridable

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  data_in/sel are meaningful this cycle
- sel  in  SEL_W  input index; 0 selects data_in[WIDTH-1:0]
- data_in  in  NUM_IN*WIDTH  packed inputs; input k occupies [k*WIDTH +: WIDTH]
- stall  in  1  hold all output state
- flush  in  1  kill the output stage
- out_valid  out  1  data_out holds a captured result
- data_out  out  WIDTH  registered selected data
- sel_err  out  1  captured result came from an out-of-range sel

## Operation
- Reset (rst_n low, asynchronous): out_valid=0, data_out=0, sel_err=0. State is held while rst_n is low.
- Per rising edge, priority order: flush, then stall, then normal.
- flush=1: out_valid<=0, data_out<=0, sel_err<=0, regardless of stall or in_valid.
- stall=1, flush=0: all outputs hold their values. Inputs presented this cycle are dropped; upstream must hold them.
- Normal, in_valid=1, sel<NUM_IN: data_out<=input[sel], out_valid<=1, sel_err<=0.
- Normal, in_valid=1, sel>=NUM_IN (possible only when NUM_IN is not a power of 2): data_out<=0, out_valid<=1, sel_err<=1.
- Normal, in_valid=0: out_valid<=0, sel_err<=0, data_out holds its previous value. Consumers must qualify data_out with out_valid.
- sel and data_in are ignored whenever in_valid=0. X on these inputs must not propagate into data_out in that case.
- NUM_IN=2 with SEL_W=1 must reproduce the legacy select exactly: sel=0 selects input 0, sel=1 selects input 1, and the result appears one cycle later.

## Timing
- Latency: 1 cycle from input sample edge to data_out/out_valid.
- Throughput: 1 result per cycle when stall=0.
- Combinational path: sel decode plus N:1 select into the output register. No combinational input-to-output path.
- flush and stall asserted in the same cycle: flush wins.
- Reset deasserted mid-stream: the first sampling edge after release behaves as a normal edge. Nothing is replayed.
- Outputs change only on the rising edge of clk or the falling edge of rst_n.

## Structure
- Shared package mux_pkg:
  - MUX_MAX_IN = 16
  - function clog2_min1(n), used to derive SEL_W
  - default WIDTH constant XLEN = 32, shared with the core
- Sub-module mux_n_comb:
  - purely combinational N:1 selector (WIDTH, NUM_IN)
  - outputs the selected data and a range-error flag
  - instantiated once inside mux_pipe_n
- mux_pipe_n itself contains only the output register, valid/error logic and the flush/stall priority.

## Test plan
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> out_valid, data_out and sel_err go to 0 immediately, before the next clk edge.
- Select sweep, WIDTH=32, NUM_IN=4, inputs 0x11111111/0x22222222/0x33333333/0x44444444, in_valid=1, sel=0..3 on consecutive cycles -> data_out shows those four values one cycle later each, out_valid=1 throughout, sel_err=0.
- Out-of-range, NUM_IN=3, sel=3, in_valid=1 -> next cycle data_out=0, out_valid=1, sel_err=1. Following cycle with sel=1 and input 1 = 0xDEADBEEF -> data_out=0xDEADBEEF, sel_err=0.
- Stall: capture 0xA5A5A5A5, then hold stall=1 for 3 cycles while the inputs change -> data_out stays 0xA5A5A5A5 and out_valid stays 1 for all 3 cycles.
- Flush priority: stall=1 and flush=1 on the same edge with out_valid=1 -> next cycle out_valid=0, data_out=0, sel_err=0.
- Legacy equivalence, NUM_IN=2, random 1000 vectors with in_valid=1 -> data_out(t+1) equals (sel ? input1 : input0)(t) on every vector.
